// File: rtl/super_i3_bch_outer_sched_pkg.sv
// Shared types, sizes and helpers for the I.3 outer BCH decoder scheduler.
package super_i3_bch_outer_sched_pkg;

  // Outer code geometry: 8 parallel decoders over GF(2^12).
  localparam int cDEC_NUM    = 8;
  localparam int cM          = 12;
  // Chien search cycles per frame: 3860 bits spread over 8 lanes.
  localparam int cFRAME_SIZE = 483;

  // Statistics counter width and the widest width sat_add handles.
  localparam int cCNT_W      = 32;
  localparam int cSAT_W      = 64;

  typedef enum logic [1:0] {FREE, FILLED, DECODING, READOUT} buf_state_t;

  // Add b to a and clamp the result at the all-ones value of a w-bit counter.
  function automatic logic [cSAT_W-1:0] sat_add(input logic [cSAT_W-1:0] a,
                                                input logic [cSAT_W-1:0] b,
                                                input int unsigned w);
    logic [cSAT_W:0] s;
    logic [cSAT_W:0] lim;
    s   = {1'b0, a} + {1'b0, b};
    lim = ((cSAT_W+1)'(1) << w) - (cSAT_W+1)'(1);
    return cSAT_W'((s > lim) ? lim : s);
  endfunction

endpackage

// File: rtl/super_i3_bch_outer_dec_sched_if.sv
// Handshake bundle between the scheduler and the writer/syndrome/chien/reader stages.
interface super_i3_bch_outer_dec_sched_if
  import super_i3_bch_outer_sched_pkg::*;
#(
  parameter int pDEC_NUM = cDEC_NUM,
  parameter int pGF_W    = cM,
  parameter int pCNT_W   = cCNT_W
);
  logic                      iwr_done;
  logic                      owr_rdy;
  logic                      owr_ptr;
  logic                      osyn_start;
  logic                      osyn_ptr;
  logic                      ibm_val;
  logic                      ibm_ptr;
  logic                      obm_ack;
  logic                      ochien_start;
  logic                      ochien_ptr;
  logic                      ichien_done;
  logic                      ichien_ptr;
  logic [pDEC_NUM*pGF_W-1:0] ibiterr;
  logic [pDEC_NUM-1:0]       idecfail;
  logic                      ord_start;
  logic                      ord_ptr;
  logic                      ird_done;
  logic [pDEC_NUM*pGF_W-1:0] obiterr;
  logic [pDEC_NUM-1:0]       odecfail;
  logic                      ores_val;
  logic [pCNT_W-1:0]         ostat_bits;
  logic [pCNT_W-1:0]         ostat_fail;
  logic [pCNT_W-1:0]         ostat_frames;
  logic                      owdog_err;

  // Scheduler side.
  modport master (
    input  iwr_done, ibm_val, ibm_ptr, ichien_done, ichien_ptr, ibiterr, idecfail, ird_done,
    output owr_rdy, owr_ptr, osyn_start, osyn_ptr, obm_ack, ochien_start, ochien_ptr,
           ord_start, ord_ptr, obiterr, odecfail, ores_val,
           ostat_bits, ostat_fail, ostat_frames, owdog_err
  );

  // Pipeline stage side.
  modport slave (
    output iwr_done, ibm_val, ibm_ptr, ichien_done, ichien_ptr, ibiterr, idecfail, ird_done,
    input  owr_rdy, owr_ptr, osyn_start, osyn_ptr, obm_ack, ochien_start, ochien_ptr,
           ord_start, ord_ptr, obiterr, odecfail, ores_val,
           ostat_bits, ostat_fail, ostat_frames, owdog_err
  );
endinterface

// File: rtl/super_i3_bch_outer_stat_cnt.sv
// Per-frame decode statistics: failed-lane popcount, corrected-bit sum, saturating totals.
module super_i3_bch_outer_stat_cnt
  import super_i3_bch_outer_sched_pkg::*;
#(
  parameter int pDEC_NUM = cDEC_NUM,
  parameter int pGF_W    = cM,
  parameter int pCNT_W   = cCNT_W
)(
  input  logic                      iclk,
  input  logic                      iresetn,
  input  logic                      iclkena,
  input  logic                      iupd,
  input  logic [pDEC_NUM*pGF_W-1:0] ibiterr,
  input  logic [pDEC_NUM-1:0]       idecfail,
  output logic [pCNT_W-1:0]         obits,
  output logic [pCNT_W-1:0]         ofail,
  output logic [pCNT_W-1:0]         oframes
);
  localparam int cPOP_W = $clog2(pDEC_NUM+1);
  localparam int cSUM_W = pGF_W + $clog2(pDEC_NUM) + 1;

  logic [cPOP_W-1:0] nfail;
  logic [cSUM_W-1:0] bsum;
  logic [pCNT_W-1:0] cnt_bits, cnt_fail, cnt_frames;

  // Lanes that failed contribute to the fail count only; their biterr is meaningless.
  always_comb begin
    nfail = '0;
    bsum  = '0;
    for (int l = 0; l < pDEC_NUM; l++) begin
      nfail = nfail + cPOP_W'(idecfail[l]);
      if (!idecfail[l]) bsum = bsum + cSUM_W'(ibiterr[l*pGF_W +: pGF_W]);
    end
  end

  // Saturating accumulation, one update per completed frame.
  always_ff @(posedge iclk or negedge iresetn) begin
    if (!iresetn) begin
      cnt_bits   <= '0;
      cnt_fail   <= '0;
      cnt_frames <= '0;
    end else if (iclkena && iupd) begin
      cnt_bits   <= pCNT_W'(sat_add(cSAT_W'(cnt_bits),   cSAT_W'(bsum),  pCNT_W));
      cnt_fail   <= pCNT_W'(sat_add(cSAT_W'(cnt_fail),   cSAT_W'(nfail), pCNT_W));
      cnt_frames <= pCNT_W'(sat_add(cSAT_W'(cnt_frames), cSAT_W'(1),     pCNT_W));
    end
  end

  assign obits   = cnt_bits;
  assign ofail   = cnt_fail;
  assign oframes = cnt_frames;
endmodule

// File: rtl/super_i3_bch_outer_dec_sched.sv
// Ping-pong buffer scheduler for the I.3 outer BCH decoder: writer -> syn/BM -> chien -> reader.
module super_i3_bch_outer_dec_sched
  import super_i3_bch_outer_sched_pkg::*;
#(
  parameter int pDEC_NUM = cDEC_NUM,
  parameter int pGF_W    = cM,
  parameter int pCNT_W   = cCNT_W,
  parameter int pWDOG    = 1024
)(
  input  logic                          iclk,
  input  logic                          iresetn,
  input  logic                          iclkena,
  super_i3_bch_outer_dec_sched_if.master bus
);
  // The watchdog never fires before a healthy chien run could have finished.
  localparam int cWDOG = (pWDOG > cFRAME_SIZE + 8) ? pWDOG : cFRAME_SIZE + 9;
  localparam int cWD_W = $clog2(cWDOG + 1);

  buf_state_t                st [2];
  logic                      wr_ptr, last_fill;
  logic                      syn_busy, syn_start_q, syn_ptr_q;
  logic                      chien_busy, chien_ptr_q;
  logic                      rd_busy, rd_start_q, rd_ptr_q;
  logic                      res_val_q, wdog_err_q;
  logic [cWD_W-1:0]          wd_cnt;
  logic [pDEC_NUM*pGF_W-1:0] biterr_q;
  logic [pDEC_NUM-1:0]       decfail_q;

  logic f0, f1, r0, r1;
  logic wr_ok, syn_go, syn_sel, chien_start, wd_fire, rd_go, rd_sel;

  assign f0 = (st[0] == FILLED);
  assign f1 = (st[1] == FILLED);
  assign r0 = (st[0] == READOUT);
  assign r1 = (st[1] == READOUT);

  // Writes into a non-free buffer are dropped.
  assign wr_ok       = iclkena & bus.iwr_done & (st[wr_ptr] == FREE);
  // With both buffers filled, the one not written last is the older frame.
  assign syn_go      = ~syn_busy & (f0 | f1);
  assign syn_sel     = (f0 & f1) ? ~last_fill : f1;
  // A done in the same cycle as a BM result pushes the new start out by one cycle.
  assign chien_start = iclkena & bus.ibm_val & ~chien_busy & ~bus.ichien_done;
  assign wd_fire     = chien_busy & ~bus.ichien_done & (wd_cnt == cWD_W'(cWDOG - 1));
  assign rd_go       = ~rd_busy & (r0 | r1);
  assign rd_sel      = ~r0;

  // Buffer state machines, stage busy flags, result capture and watchdog.
  always_ff @(posedge iclk or negedge iresetn) begin
    if (!iresetn) begin
      st[0]       <= FREE;
      st[1]       <= FREE;
      wr_ptr      <= 1'b0;
      last_fill   <= 1'b0;
      syn_busy    <= 1'b0;
      syn_start_q <= 1'b0;
      syn_ptr_q   <= 1'b0;
      chien_busy  <= 1'b0;
      chien_ptr_q <= 1'b0;
      rd_busy     <= 1'b0;
      rd_start_q  <= 1'b0;
      rd_ptr_q    <= 1'b0;
      res_val_q   <= 1'b0;
      wdog_err_q  <= 1'b0;
      wd_cnt      <= '0;
      biterr_q    <= '0;
      decfail_q   <= '0;
    end else if (iclkena) begin
      syn_start_q <= 1'b0;
      rd_start_q  <= 1'b0;
      res_val_q   <= 1'b0;

      if (wr_ok) begin
        st[wr_ptr] <= FILLED;
        wr_ptr     <= ~wr_ptr;
        last_fill  <= wr_ptr;
      end

      if (syn_go) begin
        st[syn_sel] <= DECODING;
        syn_start_q <= 1'b1;
        syn_ptr_q   <= syn_sel;
        syn_busy    <= 1'b1;
      end else if (chien_start) begin
        syn_busy <= 1'b0;
      end

      if (chien_start) begin
        chien_busy  <= 1'b1;
        chien_ptr_q <= bus.ibm_ptr;
        wd_cnt      <= '0;
      end else if (bus.ichien_done) begin
        chien_busy <= 1'b0;
        if (st[bus.ichien_ptr] == DECODING) st[bus.ichien_ptr] <= READOUT;
        biterr_q  <= bus.ibiterr;
        decfail_q <= bus.idecfail;
        res_val_q <= 1'b1;
      end else if (wd_fire) begin
        chien_busy       <= 1'b0;
        wdog_err_q       <= 1'b1;
        st[chien_ptr_q]  <= READOUT;
        biterr_q         <= '0;
        decfail_q        <= '1;
        res_val_q        <= 1'b1;
      end else if (chien_busy) begin
        wd_cnt <= wd_cnt + cWD_W'(1);
      end

      if (rd_go) begin
        rd_start_q <= 1'b1;
        rd_ptr_q   <= rd_sel;
        rd_busy    <= 1'b1;
      end else if (rd_busy && bus.ird_done) begin
        st[rd_ptr_q] <= FREE;
        rd_busy      <= 1'b0;
      end
    end
  end

  super_i3_bch_outer_stat_cnt #(
    .pDEC_NUM (pDEC_NUM),
    .pGF_W    (pGF_W),
    .pCNT_W   (pCNT_W)
  ) u_stat (
    .iclk     (iclk),
    .iresetn  (iresetn),
    .iclkena  (iclkena),
    .iupd     (bus.ichien_done),
    .ibiterr  (bus.ibiterr),
    .idecfail (bus.idecfail),
    .obits    (bus.ostat_bits),
    .ofail    (bus.ostat_fail),
    .oframes  (bus.ostat_frames)
  );

  // Registered pulses are masked while the clock enable is low so each shows once.
  assign bus.owr_rdy      = (st[wr_ptr] == FREE);
  assign bus.owr_ptr      = wr_ptr;
  assign bus.osyn_start   = syn_start_q & iclkena;
  assign bus.osyn_ptr     = syn_ptr_q;
  assign bus.ochien_start = chien_start;
  assign bus.obm_ack      = chien_start;
  assign bus.ochien_ptr   = bus.ibm_ptr;
  assign bus.ord_start    = rd_start_q & iclkena;
  assign bus.ord_ptr      = rd_ptr_q;
  assign bus.obiterr      = biterr_q;
  assign bus.odecfail     = decfail_q;
  assign bus.ores_val     = res_val_q & iclkena;
  assign bus.owdog_err    = wdog_err_q;
endmodule

// File: doc/super_i3_bch_outer_dec_sched.md
Name: super_i3_bch_outer_dec_sched

Overview:
Scheduler for the I.3 outer BCH (3860,3824) decoder array. It owns the two ping-pong frame buffers shared by the input writer, the syndrome/Berlekamp-Massey (BM) stage, the chien search stage and the output reader. It tracks the state of each buffer, starts each stage on the correct buffer pointer and throttles the stages when a resource is busy. It also registers the per-frame biterr/decfail results and keeps saturating statistics counters.

Parameters:
pDEC_NUM, 8, number of parallel BCH decoders (must equal cDEC_NUM)
pGF_W, 12, GF(2^m) symbol width of the biterr fields
pCNT_W, 32, width of the statistics counters
pWDOG, 1024, chien watchdog limit in cycles; must be greater than cFRAME_SIZE+8

Ports:
iclk  in  1  clock
iresetn  in  1  asynchronous active-low reset
iclkena  in  1  clock enable; all state holds when low
iwr_done  in  1  input writer finished a frame into buffer owr_ptr
owr_rdy  out  1  a free buffer is available for writing
owr_ptr  out  1  buffer the writer must fill next
osyn_start  out  1  one-cycle start pulse to the syndrome/BM stage
osyn_ptr  out  1  buffer for osyn_start
ibm_val  in  1  BM locator polynomial valid (held until accepted)
ibm_ptr  in  1  buffer of the BM result
obm_ack  out  1  BM result accepted; equals ochien_start
ochien_start  out  1  drives the chien iloc_poly_val
ochien_ptr  out  1  drives the chien iloc_poly_ptr
ichien_done  in  1  chien odone
ichien_ptr  in  1  chien odone_ptr
ibiterr  in  pDEC_NUM*pGF_W  chien obiterr, valid with ichien_done
idecfail  in  pDEC_NUM  chien odecfail, valid with ichien_done
ord_start  out  1  one-cycle pulse: the output reader may read buffer ord_ptr
ord_ptr  out  1  buffer to read
ird_done  in  1  reader finished buffer ord_ptr
obiterr  out  pDEC_NUM*pGF_W  registered per-frame biterr
odecfail  out  pDEC_NUM  registered per-frame decfail
ores_val  out  1  one-cycle pulse when obiterr/odecfail update
ostat_bits  out  pCNT_W  saturating total of corrected bits (frames without decfail only)
ostat_fail  out  pCNT_W  saturating count of decoder-frames with decfail
ostat_frames  out  pCNT_W  saturating count of frames completed
owdog_err  out  1  sticky: chien did not finish within pWDOG cycles

Behaviour:
- Reset values: all outputs 0 except owr_rdy=1. Both buffers FREE. owr_ptr=0. Counters 0.
- Each buffer has a 2-bit state: FREE → FILLED → DECODING → READOUT → FREE.
- Write side:
  - owr_rdy = (state[owr_ptr]==FREE).
  - iwr_done while owr_rdy sets that buffer to FILLED and toggles owr_ptr.
  - iwr_done while owr_rdy=0 is a protocol error: it is ignored and does not change state.
- Syndrome start:
  - syn_busy is set by osyn_start and cleared by obm_ack.
  - If syn_busy=0 and some buffer is FILLED, osyn_start pulses one cycle later (registered), with osyn_ptr set to that buffer and the buffer moved to DECODING.
  - If both buffers are FILLED, the buffer filled first is started first (1-bit age flag).
- Chien start:
  - chien_busy is set on ochien_start and cleared on ichien_done.
  - ochien_start = ibm_val & !chien_busy & !ichien_done_pending. The signal is combinational so that chien sees the pulse in the cycle iloc_poly is valid. ochien_ptr = ibm_ptr.
- Chien done (ichien_done):
  - Move buffer ichien_ptr to READOUT.
  - Capture ibiterr/idecfail into obiterr/odecfail and pulse ores_val on the next cycle.
  - Update the counters the same cycle as ores_val:
    - ostat_frames +1.
    - ostat_fail + popcount(idecfail).
    - ostat_bits + the sum of ibiterr over lanes with decfail=0.
  - All counters saturate at all-ones.
- Read side:
  - ord_start pulses one cycle after a buffer enters READOUT, provided rd_busy=0; ord_start sets rd_busy.
  - ird_done frees buffer ord_ptr and clears rd_busy.
  - A second READOUT buffer waits until rd_busy clears.
- Watchdog:
  - A counter runs while chien_busy and resets on ochien_start.
  - Reaching pWDOG sets owdog_err (sticky until reset), forces that buffer to READOUT with odecfail all-ones, and clears chien_busy.
- Simultaneous events:
  - iwr_done and ird_done on the same buffer cannot collide, because the states are exclusive.
  - ichien_done and ibm_val in the same cycle: the new start is deferred by 1 cycle.
  - A buffer leaving FREE and another entering FREE in the same cycle are both applied.
- iresetn assertion mid-frame aborts everything asynchronously and returns to the reset values. Upstream stages must be reset together with this block.
- iclkena=0 freezes all state and suppresses all pulses.

Decomposition:
- Package super_i3_bch_outer_sched_pkg holds:
  - buf_state_t enum {FREE, FILLED, DECODING, READOUT};
  - the counter widths;
  - the sat_add function.
- cDEC_NUM, cM and cFRAME_SIZE come from the existing outer types header.
- One sub-module: super_i3_bch_outer_stat_cnt. It contains the popcount, the masked biterr sum and the three saturating counters.

Test Plan:
- Single frame. iwr_done with owr_ptr=0 → osyn_start with osyn_ptr=0. ibm_val, ptr 0 → ochien_start the same cycle. ichien_done with biterr lane0=3, no decfail → ord_start ptr 0, ostat_bits=3, ostat_frames=1.
- Back-to-back. Write buffers 0 and 1 consecutively → owr_rdy=0 after the second write. A third iwr_done is ignored. ird_done on 0 → owr_rdy=1, owr_ptr=0.
- Collision. ibm_val and ichien_done in the same cycle → ochien_start exactly 1 cycle later, with the correct ptr.
- Decfail. idecfail=8'b0000_0101 with biterr lanes 0,2=5 and lane1=2 → ostat_fail=2, ostat_bits=2.
- Saturation. Preload ostat_bits near all-ones (force) and add 4 → holds at all-ones.
- Watchdog and reset. Withhold ichien_done for pWDOG cycles → owdog_err=1 and odecfail all-ones. Then pulse iresetn low mid-write → all outputs return to reset values asynchronously.
